// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a built-in runtime-loaded baud divisor,
// optional parity, configurable stop length and a sticky done flag.
module uart_tx_param #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DVSR_W     = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              tx_start,
  input  logic [DBIT-1:0]   din,
  output logic              tx_ready,
  output logic              tx_done_tick,
  output logic              tx_done,
  input  logic              done_clr,
  output logic              tx
);

  localparam int unsigned TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX);
  localparam int unsigned BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [DVSR_W-1:0]   dvsr_q, dvsr_d;
  logic [DVSR_W-1:0]   div_q, div_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DBIT-1:0]     sreg_q, sreg_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                done_tick_q, done_tick_d;

  logic                s_tick_c;
  logic                accept_c;
  logic                last_os_c;
  logic                last_sb_c;
  logic                last_bit_c;

  assign s_tick_c   = (div_q == dvsr_q);
  assign accept_c   = (state_q == IDLE) && tx_start;
  assign last_os_c  = s_tick_c && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign last_sb_c  = s_tick_c && (tick_q == TICK_W'(SB_TICK - 1));
  assign last_bit_c = (bit_q == BIT_W'(DBIT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_start) state_d = START;
      START:   if (last_os_c) state_d = DATA;
      DATA:    if (last_os_c && last_bit_c) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (last_os_c) state_d = STOP;
      STOP:    if (last_sb_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divisor, tick/bit counters and shift register; everything restarts on accept
  always_comb begin
    dvsr_d = dvsr_q;
    div_d  = div_q;
    tick_d = tick_q;
    bit_d  = bit_q;
    sreg_d = sreg_q;
    par_d  = par_q;
    if (accept_c) begin
      dvsr_d = dvsr;
      div_d  = '0;
      tick_d = '0;
      bit_d  = '0;
      sreg_d = din;
      par_d  = (^din) ^ (PARITY_ODD != 0);
    end else if (state_q != IDLE) begin
      div_d = s_tick_c ? '0 : div_q + DVSR_W'(1);
      if (s_tick_c) begin
        if ((state_q == STOP) ? last_sb_c : last_os_c) tick_d = '0;
        else                                           tick_d = tick_q + TICK_W'(1);
      end
      if (state_q == DATA && last_os_c) begin
        sreg_d = sreg_q >> 1;
        bit_d  = last_bit_c ? '0 : bit_q + BIT_W'(1);
      end
    end
  end

  // Output logic, computed from the next state so the pin is a clean flop
  always_comb begin
    ready_d     = (state_d == IDLE);
    done_tick_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    if (done_tick_d)                done_d = 1'b1;
    else if (done_clr || accept_c)  done_d = 1'b0;
    else                            done_d = done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr_q      <= '0;
      div_q       <= '0;
      tick_q      <= '0;
      bit_q       <= '0;
      sreg_q      <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      done_tick_q <= 1'b0;
    end else begin
      dvsr_q      <= dvsr_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      sreg_q      <= sreg_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      done_tick_q <= done_tick_d;
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = ready_q;
  assign tx_done      = done_q;
  assign tx_done_tick = done_tick_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter. Successor to the fixed 8N1 transmitter-plus-free-running-divisor pair.
- Integrates the baud/oversample tick divisor, loaded at runtime.
- Configurable data width, optional even/odd parity and stop length.
- Provides a ready/busy indication and a sticky, clearable done flag.
- Sits between a host-side command/FIFO block and the serial pin.

Parameters:
- DBIT, 8: data bits per frame (5..9).
- OVERSAMPLE, 16: s_ticks per start/data/parity bit (>=2).
- SB_TICK, 16: s_ticks in the stop period (16/24/32 = 1/1.5/2 stop bits at OVERSAMPLE=16).
- DVSR_W, 16: width of the baud divisor input.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity (only used when PARITY_EN=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dvsr  in  DVSR_W  divisor; s_tick asserts every dvsr+1 clocks; sampled at frame start.
- tx_start  in  1  request to send din; honoured only when tx_ready=1.
- din  in  DBIT  frame payload, sampled on the accepting edge.
- tx_ready  out  1  1 when idle and able to accept tx_start.
- tx_done_tick  out  1  one-clock pulse at the end of the stop period.
- tx_done  out  1  sticky completion flag.
- done_clr  in  1  clears tx_done.
- tx  out  1  registered serial line; idle high.

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_done=0, tx_done_tick=0. State IDLE. Divisor counter, tick counter, bit counter and shift register all 0.
- Reset asserted mid-frame: tx returns to 1 immediately (async) and the frame is abandoned. No tx_done_tick is issued.
- Divisor:
  - The counter counts 0..dvsr_q and wraps to 0; s_tick=1 when count==dvsr_q.
  - dvsr_q is captured from dvsr at frame acceptance. Changes to dvsr mid-frame have no effect.
  - The counter is forced to 0 on acceptance, so every bit is exact.
  - dvsr=0 gives s_tick every clock.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready=1, tx=1. If tx_start=1, latch din and compute the parity bit (XOR of din, inverted if PARITY_ODD), then go to START. tx goes low on the next clock edge (1-clock latency from the accepting edge).
  - START: tx=0 for OVERSAMPLE s_ticks, then DATA.
  - DATA: shift out LSB first. Each bit lasts OVERSAMPLE s_ticks. After DBIT bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity bit for OVERSAMPLE s_ticks, then STOP.
  - STOP: tx=1 for SB_TICK s_ticks. On the final tick, assert tx_done_tick for one clock and go to IDLE.
- tx_ready is 0 in all states other than IDLE. tx_start while busy is ignored (not queued).
- A new frame may be accepted in the cycle after the STOP-to-IDLE transition.
- Frame length in clocks: ((1+DBIT+PARITY_EN)*OVERSAMPLE + SB_TICK)*(dvsr+1).
- tx_done priority:
  - tx_done_tick sets it.
  - Otherwise done_clr or an accepted tx_start clears it.
  - Otherwise it holds.
  - If set and clear occur in the same cycle, set wins.
- Bit-time and tick counters are sized to hold OVERSAMPLE-1 and SB_TICK-1. The bit counter is sized for DBIT-1. No counter overflows across parameter ranges.

Test Plan:
1. Defaults, dvsr=3, send din=0xA5: tx low 1 clock after accept. Bit period is 64 clocks. Line shows 0,1,0,1,0,0,1,0,1,1. tx_done_tick occurs 640 clocks after the tx falling edge, then tx_done=1 and tx_ready=1.
2. PARITY_EN=1 with din=0xA5: even parity gives parity bit 0; PARITY_ODD=1 gives 1. Frame is 704 clocks at dvsr=3.
3. SB_TICK=32, DBIT=7, dvsr=0, din=0x7F: stop high for 32 clocks. Total frame 160 clocks. Only 7 data bits are shifted.
4. Pulse tx_start with din=0x00 at mid-frame of a 0x55 transfer: the second request is ignored, and the line carries only 0x55. Changing dvsr mid-frame leaves the bit period unchanged.
5. Hold done_clr=1 on the same clock as tx_done_tick: tx_done=1. Then pulse done_clr alone: tx_done=0. An accepted tx_start also clears it.
6. Assert reset in the DATA state: tx=1 and tx_ready=1 at once, no tx_done_tick. After release, a fresh 0x3C frame transmits correctly.
